// File: rtl/eth_idma_sched.sv
// Round-robin TX/RX descriptor scheduler driving the iDMA 1D request/response handshake.
// Define ETH_IDMA_SCHED_IRQ_EN to add the sticky completion/error interrupt (irq_o, irq_clr_i).
module eth_idma_sched #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned TFLenWidth     = 32,
    parameter int unsigned MaxOutstanding = 4,
    parameter logic [2:0]  ProtoAxi       = 3'd0,
    parameter logic [2:0]  ProtoAxis      = 3'd6,
    parameter int unsigned CntWidth       = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              tx_desc_valid_i,
    output logic                              tx_desc_ready_o,
    input  logic [AddrWidth-1:0]              tx_src_addr_i,
    input  logic [TFLenWidth-1:0]             tx_len_i,
    input  logic                              rx_desc_valid_i,
    output logic                              rx_desc_ready_o,
    input  logic [AddrWidth-1:0]              rx_dst_addr_i,
    input  logic [TFLenWidth-1:0]             rx_len_i,
    output logic                              idma_req_valid_o,
    input  logic                              idma_req_ready_i,
    output logic [AddrWidth-1:0]              idma_src_addr_o,
    output logic [AddrWidth-1:0]              idma_dst_addr_o,
    output logic [TFLenWidth-1:0]             idma_len_o,
    output logic [2:0]                        idma_src_protocol_o,
    output logic [2:0]                        idma_dst_protocol_o,
    input  logic                              idma_rsp_valid_i,
    output logic                              idma_rsp_ready_o,
    input  logic                              idma_rsp_error_i,
    output logic                              done_valid_o,
    input  logic                              done_ready_i,
    output logic                              done_dir_o,
    output logic                              done_error_o,
    output logic [$clog2(MaxOutstanding):0]   outstanding_o,
    output logic [CntWidth-1:0]               tx_count_o,
    output logic [CntWidth-1:0]               rx_count_o,
    output logic                              busy_o
`ifdef ETH_IDMA_SCHED_IRQ_EN
    ,
    input  logic                              irq_clr_i,
    output logic                              irq_o
`endif
);
    localparam int unsigned PtrW = $clog2(MaxOutstanding);
    localparam int unsigned OutW = PtrW + 1;
    localparam logic [OutW-1:0] MaxOut = OutW'(MaxOutstanding);

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

    state_e                state_q, state_d;
    logic                  prio_q, prio_d;
    logic                  grant_tx, grant_rx;
    logic                  req_hs, rsp_hs;
    logic [AddrWidth-1:0]  src_q, src_d, dst_q, dst_d;
    logic [TFLenWidth-1:0] len_q, len_d;
    logic [2:0]            sproto_q, sproto_d, dproto_q, dproto_d;
    logic                  dir_q, dir_d;
    logic [MaxOutstanding-1:0] tag_q;
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [OutW-1:0]       out_q, out_d;
    logic                  dvalid_q, dvalid_d, ddir_q, ddir_d, derr_q, derr_d;
    logic [CntWidth-1:0]   txc_q, txc_d, rxc_q, rxc_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_tx || grant_rx) state_d = ISSUE;
            ISSUE:   if (idma_req_ready_i)     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant is combinational: the prioritised requester wins if valid, else the other one.
    always_comb begin
        grant_tx = 1'b0;
        grant_rx = 1'b0;
        if (state_q == IDLE && out_q < MaxOut) begin
            if (!prio_q) begin
                grant_tx = tx_desc_valid_i;
                grant_rx = !tx_desc_valid_i && rx_desc_valid_i;
            end else begin
                grant_rx = rx_desc_valid_i;
                grant_tx = !rx_desc_valid_i && tx_desc_valid_i;
            end
        end
        tx_desc_ready_o  = grant_tx;
        rx_desc_ready_o  = grant_rx;
        idma_req_valid_o = (state_q == ISSUE);
    end

    assign req_hs           = idma_req_valid_o && idma_req_ready_i;
    assign idma_rsp_ready_o = (!dvalid_q || done_ready_i) && (out_q != '0);
    assign rsp_hs           = idma_rsp_valid_i && idma_rsp_ready_o;

    always_comb begin
        prio_d   = prio_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        sproto_d = sproto_q;
        dproto_d = dproto_q;
        dir_d    = dir_q;
        if (grant_tx) begin
            prio_d   = 1'b1;
            src_d    = tx_src_addr_i;
            dst_d    = '0;
            len_d    = tx_len_i;
            sproto_d = ProtoAxi;
            dproto_d = ProtoAxis;
            dir_d    = 1'b0;
        end else if (grant_rx) begin
            prio_d   = 1'b0;
            src_d    = '0;
            dst_d    = rx_dst_addr_i;
            len_d    = rx_len_i;
            sproto_d = ProtoAxis;
            dproto_d = ProtoAxi;
            dir_d    = 1'b1;
        end

        out_d = out_q;
        if (req_hs && !rsp_hs)      out_d = out_q + OutW'(1);
        else if (!req_hs && rsp_hs) out_d = out_q - OutW'(1);

        // Responses arrive in issue order, so the FIFO head names the direction.
        dvalid_d = dvalid_q;
        ddir_d   = ddir_q;
        derr_d   = derr_q;
        txc_d    = txc_q;
        rxc_d    = rxc_q;
        if (rsp_hs) begin
            dvalid_d = 1'b1;
            ddir_d   = tag_q[rd_ptr_q];
            derr_d   = idma_rsp_error_i;
            if (tag_q[rd_ptr_q]) rxc_d = rxc_q + CntWidth'(1);
            else                 txc_d = txc_q + CntWidth'(1);
        end else if (done_ready_i) begin
            dvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prio_q   <= 1'b0;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            sproto_q <= '0;
            dproto_q <= '0;
            dir_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            out_q    <= '0;
            dvalid_q <= 1'b0;
            ddir_q   <= 1'b0;
            derr_q   <= 1'b0;
            txc_q    <= '0;
            rxc_q    <= '0;
        end else begin
            prio_q   <= prio_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            sproto_q <= sproto_d;
            dproto_q <= dproto_d;
            dir_q    <= dir_d;
            if (req_hs) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (rsp_hs) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            out_q    <= out_d;
            dvalid_q <= dvalid_d;
            ddir_q   <= ddir_d;
            derr_q   <= derr_d;
            txc_q    <= txc_d;
            rxc_q    <= rxc_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (req_hs) tag_q[wr_ptr_q] <= dir_q;
    end

    assign idma_src_addr_o     = src_q;
    assign idma_dst_addr_o     = dst_q;
    assign idma_len_o          = len_q;
    assign idma_src_protocol_o = sproto_q;
    assign idma_dst_protocol_o = dproto_q;
    assign done_valid_o        = dvalid_q;
    assign done_dir_o          = ddir_q;
    assign done_error_o        = derr_q;
    assign outstanding_o       = out_q;
    assign tx_count_o          = txc_q;
    assign rx_count_o          = rxc_q;
    assign busy_o              = idma_req_valid_o || (out_q != '0) || dvalid_q;

`ifdef ETH_IDMA_SCHED_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk_i) begin
        if (!rst_ni)                                             irq_q <= 1'b0;
        else if ((dvalid_q && done_ready_i) || (rsp_hs && idma_rsp_error_i)) irq_q <= 1'b1;
        else if (irq_clr_i)                                      irq_q <= 1'b0;
    end
    assign irq_o = irq_q;
`endif
endmodule

// File: tb/tb_eth_idma_sched.sv
// Self-checking bench for eth_idma_sched: vector table, directed corner cases, random vs. model.
module tb_eth_idma_sched;
    localparam int MO = 4;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        tx_desc_valid_i, tx_desc_ready_o;
    logic [31:0] tx_src_addr_i, tx_len_i;
    logic        rx_desc_valid_i, rx_desc_ready_o;
    logic [31:0] rx_dst_addr_i, rx_len_i;
    logic        idma_req_valid_o, idma_req_ready_i;
    logic [31:0] idma_src_addr_o, idma_dst_addr_o, idma_len_o;
    logic [2:0]  idma_src_protocol_o, idma_dst_protocol_o;
    logic        idma_rsp_valid_i, idma_rsp_ready_o, idma_rsp_error_i;
    logic        done_valid_o, done_ready_i, done_dir_o, done_error_o;
    logic [2:0]  outstanding_o;
    logic [15:0] tx_count_o, rx_count_o;
    logic        busy_o;
`ifdef ETH_IDMA_SCHED_IRQ_EN
    logic        irq_clr_i, irq_o;
`endif

    always #5 clk = ~clk;

    eth_idma_sched #(
        .AddrWidth(32), .TFLenWidth(32), .MaxOutstanding(MO),
        .ProtoAxi(3'd0), .ProtoAxis(3'd6), .CntWidth(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .tx_desc_valid_i(tx_desc_valid_i), .tx_desc_ready_o(tx_desc_ready_o),
        .tx_src_addr_i(tx_src_addr_i), .tx_len_i(tx_len_i),
        .rx_desc_valid_i(rx_desc_valid_i), .rx_desc_ready_o(rx_desc_ready_o),
        .rx_dst_addr_i(rx_dst_addr_i), .rx_len_i(rx_len_i),
        .idma_req_valid_o(idma_req_valid_o), .idma_req_ready_i(idma_req_ready_i),
        .idma_src_addr_o(idma_src_addr_o), .idma_dst_addr_o(idma_dst_addr_o),
        .idma_len_o(idma_len_o), .idma_src_protocol_o(idma_src_protocol_o),
        .idma_dst_protocol_o(idma_dst_protocol_o),
        .idma_rsp_valid_i(idma_rsp_valid_i), .idma_rsp_ready_o(idma_rsp_ready_o),
        .idma_rsp_error_i(idma_rsp_error_i),
        .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
        .done_dir_o(done_dir_o), .done_error_o(done_error_o),
        .outstanding_o(outstanding_o), .tx_count_o(tx_count_o), .rx_count_o(rx_count_o),
        .busy_o(busy_o)
`ifdef ETH_IDMA_SCHED_IRQ_EN
        , .irq_clr_i(irq_clr_i), .irq_o(irq_o)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        tx_v;
        logic        rx_v;
        logic        exp_txr;
        logic        exp_rxr;
        logic [31:0] exp_src;
        logic [31:0] exp_dst;
    } arb_vec_t;
    arb_vec_t vecs [8];

    // Behavioural reference state
    logic        q_dir [$];
    logic        m_pend, m_dir, m_prio, m_dv, m_dd, m_de, m_irq;
    logic [31:0] m_src, m_dst, m_len;
    logic [2:0]  m_sp, m_dp;
    logic [15:0] m_txc, m_rxc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        tx_desc_valid_i = 0; tx_src_addr_i = 0; tx_len_i = 0;
        rx_desc_valid_i = 0; rx_dst_addr_i = 0; rx_len_i = 0;
        idma_req_ready_i = 0; idma_rsp_valid_i = 0; idma_rsp_error_i = 0;
        done_ready_i = 0;
`ifdef ETH_IDMA_SCHED_IRQ_EN
        irq_clr_i = 0;
`endif
    endtask

    task automatic do_reset();
        set_idle();
        rst_ni = 0;
        cyc(); cyc();
        rst_ni = 1;
        q_dir.delete();
        m_pend = 0; m_dir = 0; m_prio = 0; m_dv = 0; m_dd = 0; m_de = 0; m_irq = 0;
        m_src = 0; m_dst = 0; m_len = 0; m_sp = 0; m_dp = 0; m_txc = 0; m_rxc = 0;
    endtask

    task automatic check_zero(input string p);
        chk({p, "_txr"}, tx_desc_ready_o, 0);
        chk({p, "_rxr"}, rx_desc_ready_o, 0);
        chk({p, "_reqv"}, idma_req_valid_o, 0);
        chk({p, "_src"}, idma_src_addr_o, 0);
        chk({p, "_dst"}, idma_dst_addr_o, 0);
        chk({p, "_len"}, idma_len_o, 0);
        chk({p, "_proto"}, {idma_src_protocol_o, idma_dst_protocol_o}, 0);
        chk({p, "_rspr"}, idma_rsp_ready_o, 0);
        chk({p, "_done"}, {done_valid_o, done_dir_o, done_error_o}, 0);
        chk({p, "_outst"}, outstanding_o, 0);
        chk({p, "_cnt"}, {tx_count_o, rx_count_o}, 0);
        chk({p, "_busy"}, busy_o, 0);
`ifdef ETH_IDMA_SCHED_IRQ_EN
        chk({p, "_irq"}, irq_o, 0);
`endif
    endtask

    initial begin
        int  issued;
        logic vld [2];
        logic gnt, gdir, rsp_hs;

        vecs[0] = '{1, 1, 1, 0, 32'h1000, 32'h0};
        vecs[1] = '{1, 1, 0, 1, 32'h0,    32'h8001};
        vecs[2] = '{0, 1, 0, 1, 32'h0,    32'h8002};
        vecs[3] = '{1, 0, 1, 0, 32'h1030, 32'h0};
        vecs[4] = '{1, 0, 1, 0, 32'h1040, 32'h0};
        vecs[5] = '{0, 0, 0, 0, 32'h0,    32'h0};
        vecs[6] = '{1, 1, 0, 1, 32'h0,    32'h8006};
        vecs[7] = '{1, 1, 1, 0, 32'h1070, 32'h0};

        do_reset();
        #1;
        check_zero("reset");

        // Arbitration table: backend accepts requests and answers immediately
        idma_req_ready_i = 1; idma_rsp_valid_i = 1; done_ready_i = 1;
        for (int i = 0; i < 8; i++) begin
            tx_desc_valid_i = vecs[i].tx_v;
            rx_desc_valid_i = vecs[i].rx_v;
            tx_src_addr_i   = 32'h1000 + 32'(i) * 16;
            rx_dst_addr_i   = 32'h8000 + 32'(i);
            #1;
            chk($sformatf("arb%0d_txr", i), tx_desc_ready_o, vecs[i].exp_txr);
            chk($sformatf("arb%0d_rxr", i), rx_desc_ready_o, vecs[i].exp_rxr);
            cyc();
            tx_desc_valid_i = 0; rx_desc_valid_i = 0;
            #1;
            chk($sformatf("arb%0d_reqv", i), idma_req_valid_o, vecs[i].exp_txr | vecs[i].exp_rxr);
            if (vecs[i].exp_txr || vecs[i].exp_rxr) begin
                chk($sformatf("arb%0d_src", i), idma_src_addr_o, vecs[i].exp_src);
                chk($sformatf("arb%0d_dst", i), idma_dst_addr_o, vecs[i].exp_dst);
            end
            cyc();
        end

        // Single TX
        do_reset();
        tx_desc_valid_i = 1; tx_src_addr_i = 32'h1000; tx_len_i = 64;
        #1; chk("stx_txr", tx_desc_ready_o, 1);
        cyc(); tx_desc_valid_i = 0; #1;
        chk("stx_reqv", idma_req_valid_o, 1);
        chk("stx_src", idma_src_addr_o, 32'h1000);
        chk("stx_dst", idma_dst_addr_o, 0);
        chk("stx_len", idma_len_o, 64);
        chk("stx_proto", {idma_src_protocol_o, idma_dst_protocol_o}, {3'd0, 3'd6});
        chk("stx_busy", busy_o, 1);
        idma_req_ready_i = 1;
        cyc(); idma_req_ready_i = 0; #1;
        chk("stx_outst", outstanding_o, 1);
        chk("stx_reqv_lo", idma_req_valid_o, 0);
        idma_rsp_valid_i = 1; done_ready_i = 1; #1;
        chk("stx_rspr", idma_rsp_ready_o, 1);
        cyc(); idma_rsp_valid_i = 0; #1;
        chk("stx_done", {done_valid_o, done_dir_o, done_error_o}, 3'b100);
        chk("stx_txcnt", tx_count_o, 1);
        chk("stx_outst0", outstanding_o, 0);
        cyc(); #1;
        chk("stx_done_lo", done_valid_o, 0);

        // RX with error response (zero length forwarded unchanged)
        rx_desc_valid_i = 1; rx_dst_addr_i = 32'h4000; rx_len_i = 0; done_ready_i = 0;
        #1; chk("erx_rxr", rx_desc_ready_o, 1);
        cyc(); rx_desc_valid_i = 0; idma_req_ready_i = 1; #1;
        chk("erx_src", idma_src_addr_o, 0);
        chk("erx_dst", idma_dst_addr_o, 32'h4000);
        chk("erx_len", idma_len_o, 0);
        chk("erx_proto", {idma_src_protocol_o, idma_dst_protocol_o}, {3'd6, 3'd0});
        cyc(); idma_req_ready_i = 0; idma_rsp_valid_i = 1; idma_rsp_error_i = 1;
        cyc(); idma_rsp_valid_i = 0; idma_rsp_error_i = 0; #1;
        chk("erx_done", {done_valid_o, done_dir_o, done_error_o}, 3'b111);
        chk("erx_cnt", {tx_count_o, rx_count_o}, {16'd1, 16'd1});
`ifdef ETH_IDMA_SCHED_IRQ_EN
        chk("erx_irq", irq_o, 1);
        irq_clr_i = 1;
        cyc(); irq_clr_i = 0; #1;
        chk("erx_irq_clr", irq_o, 0);
`endif
        done_ready_i = 1;
        cyc(); #1;
        chk("erx_done_lo", done_valid_o, 0);
`ifdef ETH_IDMA_SCHED_IRQ_EN
        chk("erx_irq_done", irq_o, 1);
`endif

        // Backpressure: request held for 5 cycles while TX keeps requesting
        tx_desc_valid_i = 1; tx_src_addr_i = 32'h2000; tx_len_i = 32'd100;
        #1; chk("bp_grant", tx_desc_ready_o, 1);
        cyc(); tx_src_addr_i = 32'h2222; tx_len_i = 32'd7;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp%0d_reqv", k), idma_req_valid_o, 1);
            chk($sformatf("bp%0d_src", k), idma_src_addr_o, 32'h2000);
            chk($sformatf("bp%0d_len", k), idma_len_o, 100);
            chk($sformatf("bp%0d_txr", k), tx_desc_ready_o, 0);
            cyc();
        end
        idma_req_ready_i = 1;
        cyc(); idma_req_ready_i = 0; tx_desc_valid_i = 0;
        idma_rsp_valid_i = 1;
        cyc(); idma_rsp_valid_i = 0;
        cyc(); #1;
        chk("bp_txcnt", tx_count_o, 2);

        // Backend silent: exactly MaxOutstanding issues, then stall
        tx_desc_valid_i = 1; rx_desc_valid_i = 1; idma_req_ready_i = 1;
        issued = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (idma_req_valid_o && idma_req_ready_i) issued++;
            cyc();
        end
        #1;
        chk("full_issued", issued, MO);
        chk("full_outst", outstanding_o, MO);
        chk("full_rdy", {tx_desc_ready_o, rx_desc_ready_o}, 0);
        idma_rsp_valid_i = 1; #1;
        chk("full_rdy_rspcyc", {tx_desc_ready_o, rx_desc_ready_o}, 0);
        cyc(); idma_rsp_valid_i = 0; #1;
        chk("full_regrant", tx_desc_ready_o | rx_desc_ready_o, 1);
        chk("full_outst3", outstanding_o, 3);
        cyc(); tx_desc_valid_i = 0; rx_desc_valid_i = 0; idma_rsp_valid_i = 1; #1;
        chk("sim_reqv", idma_req_valid_o, 1);
        chk("sim_rspr", idma_rsp_ready_o, 1);
        cyc(); #1;
        chk("sim_outst", outstanding_o, 3);
        for (int k = 0; k < 20 && outstanding_o != 0; k++) cyc();
        chk("drain_outst", outstanding_o, 0);
        idma_rsp_valid_i = 0; idma_req_ready_i = 0;
        cyc();

        // Reset in the middle of ISSUE
        tx_desc_valid_i = 1; tx_src_addr_i = 32'h3000; tx_len_i = 8;
        cyc(); tx_desc_valid_i = 0; #1;
        chk("rst_mid_reqv", idma_req_valid_o, 1);
        rst_ni = 0;
        cyc(); #1;
        check_zero("rst_mid");
        rst_ni = 1;

        // Randomised traffic against the reference model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            tx_desc_valid_i  = 1'($urandom_range(0, 1));
            rx_desc_valid_i  = 1'($urandom_range(0, 1));
            tx_src_addr_i    = $urandom; tx_len_i = $urandom;
            rx_dst_addr_i    = $urandom; rx_len_i = $urandom;
            idma_req_ready_i = ($urandom_range(0, 3) != 0);
            idma_rsp_valid_i = ($urandom_range(0, 2) == 0);
            idma_rsp_error_i = ($urandom_range(0, 3) == 0);
            done_ready_i     = ($urandom_range(0, 3) != 0);
`ifdef ETH_IDMA_SCHED_IRQ_EN
            irq_clr_i        = ($urandom_range(0, 7) == 0);
`endif
            #1;
            vld[0] = tx_desc_valid_i;
            vld[1] = rx_desc_valid_i;
            gnt = 0; gdir = m_prio;
            if (!m_pend && q_dir.size() < MO) begin
                if (vld[m_prio])       begin gnt = 1; gdir = m_prio;  end
                else if (vld[!m_prio]) begin gnt = 1; gdir = !m_prio; end
            end
            chk("rnd_rdy", {tx_desc_ready_o, rx_desc_ready_o}, {gnt && !gdir, gnt && gdir});
            chk("rnd_reqv", idma_req_valid_o, m_pend);
            if (m_pend) begin
                chk("rnd_src", idma_src_addr_o, m_src);
                chk("rnd_dst", idma_dst_addr_o, m_dst);
                chk("rnd_len", idma_len_o, m_len);
                chk("rnd_proto", {idma_src_protocol_o, idma_dst_protocol_o}, {m_sp, m_dp});
            end
            chk("rnd_rspr", idma_rsp_ready_o, (!m_dv || done_ready_i) && q_dir.size() != 0);
            chk("rnd_dv", done_valid_o, m_dv);
            if (m_dv) chk("rnd_done", {done_dir_o, done_error_o}, {m_dd, m_de});
            chk("rnd_outst", outstanding_o, q_dir.size());
            chk("rnd_cnt", {tx_count_o, rx_count_o}, {m_txc, m_rxc});
            chk("rnd_busy", busy_o, m_pend || q_dir.size() != 0 || m_dv);
`ifdef ETH_IDMA_SCHED_IRQ_EN
            chk("rnd_irq", irq_o, m_irq);
`endif
            rsp_hs = idma_rsp_valid_i && (!m_dv || done_ready_i) && q_dir.size() != 0;
`ifdef ETH_IDMA_SCHED_IRQ_EN
            if ((m_dv && done_ready_i) || (rsp_hs && idma_rsp_error_i)) m_irq = 1;
            else if (irq_clr_i)                                         m_irq = 0;
`endif
            if (rsp_hs) begin
                m_dd = q_dir.pop_front();
                m_dv = 1;
                m_de = idma_rsp_error_i;
                if (m_dd) m_rxc++; else m_txc++;
            end else if (done_ready_i) begin
                m_dv = 0;
            end
            if (m_pend && idma_req_ready_i) begin
                q_dir.push_back(m_dir);
                m_pend = 0;
            end
            if (gnt) begin
                m_pend = 1;
                m_dir  = gdir;
                m_prio = !gdir;
                m_src  = gdir ? 32'h0 : tx_src_addr_i;
                m_dst  = gdir ? rx_dst_addr_i : 32'h0;
                m_len  = gdir ? rx_len_i : tx_len_i;
                m_sp   = gdir ? 3'd6 : 3'd0;
                m_dp   = gdir ? 3'd0 : 3'd6;
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/eth_idma_sched.md
# eth_idma_sched

Transfer scheduler for the Ethernet iDMA backend. It accepts TX descriptors (memory → AXI-Stream toward the MAC) and RX descriptors (AXI-Stream from the MAC → memory) from two independent requesters. It arbitrates between them round-robin and drives the backend's 1D request handshake. It matches in-order backend responses to their direction, reports completions, and keeps per-direction completion counters. It sits between the descriptor/register logic and the `idma_req`/`idma_rsp` ports of the RW AXI/AXIS backend, in the `clk_i` domain.

## Interface
Parameters:
- `AddrWidth`, 32, address width of descriptors and iDMA request
- `TFLenWidth`, 32, transfer length width (bytes)
- `MaxOutstanding`, 4, max issued-but-unanswered transfers; power of two, ≥2
- `ProtoAxi`, 3'd0, `idma_pkg` protocol code driven for the AXI side
- `ProtoAxis`, 3'd6, `idma_pkg` protocol code driven for the AXI-Stream side
- `CntWidth`, 16, width of completion counters

Ports (one clock `clk_i`; reset `rst_ni` is synchronous, active-low):
- `clk_i` in 1 — clock
- `rst_ni` in 1 — synchronous active-low reset
- `tx_desc_valid_i` in 1 — TX descriptor valid
- `tx_desc_ready_o` out 1 — TX descriptor accepted
- `tx_src_addr_i` in AddrWidth — TX source memory address
- `tx_len_i` in TFLenWidth — TX length
- `rx_desc_valid_i` in 1 — RX descriptor valid
- `rx_desc_ready_o` out 1 — RX descriptor accepted
- `rx_dst_addr_i` in AddrWidth — RX destination memory address
- `rx_len_i` in TFLenWidth — RX length
- `idma_req_valid_o` out 1 — request valid to backend
- `idma_req_ready_i` in 1 — backend accepts request
- `idma_src_addr_o` out AddrWidth — request source address (0 for RX)
- `idma_dst_addr_o` out AddrWidth — request destination address (0 for TX)
- `idma_len_o` out TFLenWidth — request length
- `idma_src_protocol_o` out 3 — source protocol code
- `idma_dst_protocol_o` out 3 — destination protocol code
- `idma_rsp_valid_i` in 1 — backend response valid
- `idma_rsp_ready_o` out 1 — response consumed
- `idma_rsp_error_i` in 1 — response carries an error
- `done_valid_o` out 1 — completion valid
- `done_ready_i` in 1 — completion consumed
- `done_dir_o` out 1 — completion direction: 0 = TX, 1 = RX
- `done_error_o` out 1 — completion error flag
- `outstanding_o` out $clog2(MaxOutstanding)+1 — number of in-flight transfers
- `tx_count_o` out CntWidth — completed TX transfers, wraps
- `rx_count_o` out CntWidth — completed RX transfers, wraps
- `busy_o` out 1 — `idma_req_valid_o` or `outstanding_o`≠0 or `done_valid_o`
- `irq_o` out 1 — present only with `ETH_IDMA_SCHED_IRQ_EN`

## Operation
- FSM states: IDLE, ISSUE.
- **IDLE:**
  - If `outstanding_o` < MaxOutstanding and at least one `*_desc_valid_i` is high, grant one requester and assert its `*_desc_ready_o` combinationally in that cycle.
  - Capture the granted descriptor into the request register and go to ISSUE.
  - The arbiter grants to the requester named by the priority pointer (`prio`, reset 0 = TX) if that one is valid, otherwise to the other.
  - After a grant, `prio` points to the non-granted direction.
- **ISSUE:**
  - `idma_req_valid_o` is high; all request fields are held stable.
  - On `idma_req_ready_i`: push the direction onto the tag FIFO (depth MaxOutstanding), increment outstanding, return to IDLE.
- **Request fields:**
  - TX: src = `tx_src_addr_i`, dst = 0, src_protocol = ProtoAxi, dst_protocol = ProtoAxis.
  - RX: src = 0, dst = `rx_dst_addr_i`, src_protocol = ProtoAxis, dst_protocol = ProtoAxi.
- **Responses** are in order:
  - `idma_rsp_ready_o` = (!`done_valid_o` || `done_ready_i`) && (tag FIFO not empty).
  - On a response handshake: pop a tag, load `done_dir_o`/`done_error_o`, set `done_valid_o`, decrement outstanding, and increment the counter matching the direction. Errors are counted too.
  - A response arriving with an empty tag FIFO is not accepted (ready low).
- Issue and response in the same cycle: outstanding unchanged; FIFO push and pop both occur.
- Counters wrap from 2^CntWidth−1 to 0.
- Zero-length descriptors are forwarded unchanged; the backend rejects them and answers with an error.

## Timing
- Reset values: all outputs 0; FSM = IDLE; `prio` = TX; FIFO empty.
- Reset mid-transfer drops all state without waiting for the backend. Reset of the backend is required concurrently.
- `*_desc_ready_o` high → `idma_req_valid_o` high on the next cycle.
- Minimum issue period is 2 cycles (one IDLE bubble per request).
- Response handshake → `done_valid_o` high on the next cycle.
- Back-to-back completions at 1 per cycle when `done_ready_i` is held high.
- When outstanding = MaxOutstanding, both `*_desc_ready_o` stay low until a response is accepted. The earliest new grant is in the cycle after that response.

## Configuration
- Macro `ETH_IDMA_SCHED_IRQ_EN`:
  - When defined: `irq_o` is a sticky register, set on every completion handshake (`done_valid_o && done_ready_i`) and on any error response. It clears only on a `rst_ni` pulse or when input `irq_clr_i` (1 bit, added with the macro) is high; set wins over clear in the same cycle.
  - Without the macro: `irq_o` and `irq_clr_i` do not exist.

## Test plan
- **Single TX:** addr 0x1000, len 64 → request src 0x1000, dst 0, protocols 0→6. With `done_ready_i` high, the completion has dir 0 and `tx_count_o` = 1.
- **TX and RX valid every cycle:** for 8 grants → alternating TX, RX, TX…, starting with TX.
- **MaxOutstanding=4, backend never responds:** exactly 4 requests issued; both desc_ready stay low; `outstanding_o` = 4.
- **Backpressure:** `idma_req_ready_i` held low for 5 cycles → request fields stable all 5 cycles; `tx_desc_ready_o` low throughout.
- **Error response on RX:** `done_error_o` = 1, dir 1, `rx_count_o` increments; with the macro defined, `irq_o` sets.
- **Simultaneous events:** issue and response in the same cycle → `outstanding_o` unchanged. Separately, reset asserted mid-ISSUE → all outputs 0 on the next cycle.
